// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline control for the 5-stage core. Sits between IF and ID and produces
// the shared stall, flush and issue controls.
//   - A shift-register scoreboard follows every issued instruction from EX
//     to WB. ID stalls on a read-after-write hazard against any pending write.
//   - A resolved redirect kills the younger stages.
//   - A halt request drains the pipe, then parks the core until reset.
//
// Build option:
//   HAZARD_WB_BYPASS_EN  The register file is write-first, so the WB entry
//                        no longer blocks readers. sb_busy_o still reports it.
//
// rst_i is asynchronous and active-low. While it is low, every output is
// forced to 0 even if ID/redirect inputs are active.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_RUN    | normal operation, issue allowed
// ST_DRAIN  | halt accepted, ID frozen, in-flight work retires (DEPTH cycles)
// ST_HALTED | pipe empty and stopped, left only through reset

module pipe_hazard_ctrl #(
    parameter int NREG         = 16,
    parameter int DEPTH        = 3,
    parameter int FLUSH_STAGES = 3,
    parameter int R0_ZERO      = 1,
    localparam int RW          = $clog2(NREG),
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    hlt_i,
    input  logic                    id_valid_i,
    input  logic [RW-1:0]           id_rs_i,
    input  logic                    id_rs_used_i,
    input  logic [RW-1:0]           id_rt_i,
    input  logic                    id_rt_used_i,
    input  logic [RW-1:0]           id_rd_i,
    input  logic                    id_we_i,
    input  logic                    redirect_i,
    output logic                    stall_o,
    output logic [FLUSH_STAGES-1:0] flush_o,
    output logic                    issue_o,
    output logic                    halted_o,
    output logic [NREG-1:0]         sb_busy_o
);

    // Number of scoreboard entries, counted from EX, that can block a reader.
`ifdef HAZARD_WB_BYPASS_EN
    localparam int HZ_N = DEPTH - 1;
`else
    localparam int HZ_N = DEPTH;
`endif

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic          v;
        logic          we;
        logic [RW-1:0] rd;
    } sb_entry_t;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    sb_entry_t       ent_q [DEPTH];
    sb_entry_t       ent_d [DEPTH];

    logic [NREG-1:0] busy_all;
    logic [NREG-1:0] busy_hz;
    logic            rs_hit;
    logic            rt_hit;
    logic            hazard;
    logic            running;
    logic            stall_raw;
    logic            issue_raw;

    // Decode pending destinations.
    // busy_all covers every entry. busy_hz covers only the entries that can
    // still block a reader, and ignores r0 when r0 is hard-wired to zero.
    always_comb begin
        busy_all = '0;
        busy_hz  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int r = 0; r < NREG; r++) begin
                if (ent_q[i].v && ent_q[i].we && (ent_q[i].rd == RW'(r))) begin
                    busy_all[r] = 1'b1;
                    if (i < HZ_N) begin
                        busy_hz[r] = 1'b1;
                    end
                end
            end
        end
        if (R0_ZERO != 0) begin
            busy_hz[0] = 1'b0;
        end
    end

    // Same-cycle RAW hazard check and the raw stall/issue decisions.
    // A redirect overrides a hazard: the ID instruction is being killed
    // anyway, so holding it would only delay the refetch.
    always_comb begin
        rs_hit    = id_rs_used_i & busy_hz[id_rs_i];
        rt_hit    = id_rt_used_i & busy_hz[id_rt_i];
        hazard    = id_valid_i & (rs_hit | rt_hit);
        running   = (state_q == ST_RUN);
        stall_raw = ~running | (hazard & ~redirect_i);
        issue_raw = id_valid_i & ~stall_raw & ~redirect_i & running;
    end

    // Output gating. Keeps every control at 0 while reset is asserted,
    // including issue/flush, which depend only on live inputs.
    always_comb begin
        stall_o   = stall_raw & rst_i;
        issue_o   = issue_raw & rst_i;
        halted_o  = (state_q == ST_HALTED) & rst_i;
        flush_o   = {FLUSH_STAGES{redirect_i & rst_i}};
        sb_busy_o = busy_all & {NREG{rst_i}};
    end

    // Scoreboard advance.
    // After the shift, entry k sits in stage EX+k. A redirect kills the
    // entries that now sit inside the flushed window beyond ID. When
    // FLUSH_STAGES is 2, only IF and ID are flushed and no entry is cleared.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = '0;
        end
        for (int i = DEPTH - 1; i > 0; i--) begin
            ent_d[i] = ent_q[i-1];
        end
        if (issue_raw) begin
            ent_d[0].v  = 1'b1;
            ent_d[0].we = id_we_i;
            ent_d[0].rd = id_rd_i;
        end
        if (redirect_i) begin
            for (int i = 0; i < FLUSH_STAGES - 2; i++) begin
                ent_d[i] = '0;
            end
        end
    end

    // Halt sequencing.
    // Once accepted, the halt is sticky. The drain counter runs
    // 0..DEPTH-1, so exactly DEPTH drain cycles are spent in ST_DRAIN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (hlt_i) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DEPTH - 1)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and scoreboard registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

endmodule
